// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of decode.
// Holds the PC and issues one instruction-memory request at a time over req/gnt/rvalid.
// Each fetched word is presented to decode with its PC and opcode field.
// Execute-stage redirects retarget the PC and kill any fetch still in flight.
// Build option: define FETCH_MISALIGN_CHECK_EN to fault on misaligned redirect targets.
// That build adds the sticky fetch_misalign output and a terminal FAULT state.
//
// Handshakes:
//   imem: imem_req stays high in REQ until imem_gnt. Exactly one rvalid follows each gnt,
//         at least one cycle later and in order. rvalid outside WAIT is ignored.
//   decode: if_valid stays high with if_instr/if_pc stable until a cycle with if_ready=1.
//           A redirect in that cycle drops the word instead of handing it over.
module instr_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode,
  output logic [2:0]      state_dbg
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic [XLEN-1:0] redir_tgt;

  // Redirect targets are word aligned; the low two bits never reach the PC.
  assign redir_tgt = redirect_pc & ~(XLEN'(3));

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_hit;
  // A misaligned redirect counts only in states that honour redirects at all.
  assign fault_hit = redirect_valid && (redirect_pc[1:0] != 2'b00) &&
                     ((state == S_REQ) || (state == S_WAIT) || (state == S_HOLD));
`endif

  // Outputs decoded from state or taken straight from registers.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign if_opcode = if_instr[6:0];
  assign state_dbg = state;

  // Fetch sequencer: PC, kill flag, decode-side output register and fault flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else
`ifdef FETCH_MISALIGN_CHECK_EN
    if (fault_hit) begin
      state          <= S_FAULT;
      if_valid       <= 1'b0;
      fetch_misalign <= 1'b1;
    end else
`endif
    begin
      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (redirect_valid) begin
            pc <= redir_tgt;
            // A request granted in the same cycle is already out; kill its data.
            if (imem_gnt) begin
              kill  <= 1'b1;
              state <= S_WAIT;
            end
          end else if (imem_gnt) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redir_tgt;
            if (imem_rvalid) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              pc       <= pc + XLEN'(4);
              if_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            pc       <= redir_tgt;
            if_valid <= 1'b0;
            state    <= S_REQ;
          end else if (if_ready) begin
            if_valid <= 1'b0;
            state    <= S_REQ;
          end
        end

        // Terminal until reset; only reachable with the misalign check built in.
        S_FAULT: state <= S_FAULT;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed table, hand sequences and a randomized run against a
// transaction-level model of the fetch stream for instr_fetch.
module tb_instr_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (RESET_PC = 0)
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [6:0]  if_opcode;
  logic [2:0]  state_dbg;

  // second DUT (RESET_PC near the top of the address space)
  logic        b_reset;
  logic        b_req, b_gnt, b_rvalid;
  logic [31:0] b_addr, b_rdata;
  logic        b_rdir;
  logic [31:0] b_rdir_pc;
  logic        b_valid, b_ready;
  logic [31:0] b_instr, b_pc;
  logic [6:0]  b_opcode;
  logic [2:0]  b_state;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_misalign, b_misalign;
`endif

  instr_fetch dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_opcode(if_opcode), .state_dbg(state_dbg)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(b_reset),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_gnt),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .redirect_valid(b_rdir), .redirect_pc(b_rdir_pc),
    .if_valid(b_valid), .if_ready(b_ready), .if_instr(b_instr),
    .if_pc(b_pc), .if_opcode(b_opcode), .state_dbg(b_state)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misalign(b_misalign)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];   // {pc, instr} of the next word decode must receive

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdir;
    logic [31:0] rdir_pc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                              input logic rdir, input logic [31:0] rdir_pc, input logic ready,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.rdir = rdir; v.rdir_pc = rdir_pc;
    v.ready = ready; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic drive_idle();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
  endtask

  // random-phase variables
  logic        pend;
  logic [31:0] pend_addr, req_addr, tgt, etgt, npc;
  logic        granted;
  int          wait_cnt;
  int          n_deliv;

  initial begin
    reset = 1'b0; drive_idle();
    b_reset = 1'b0; b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = 32'h0;
    b_rdir = 1'b0; b_rdir_pc = 32'h0; b_ready = 1'b0;

    // fetch, hold, redirect-in-WAIT, redirect-in-HOLD, redirect-in-REQ, stray rvalid
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,  0, 1,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(0,1,32'h00500093, 0,32'h0,  1, 0,32'h0,   1,32'h0,  32'h00500093));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,  1, 1,32'h4,   0,32'h0,  32'h0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(0,1,32'h00208113, 0,32'h0,  0, 0,32'h0,   1,32'h4,  32'h00208113));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,32'h0,      0,32'h0,  0, 0,32'h0,   1,32'h4,  32'h00208113));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,  1, 1,32'h8,   0,32'h0,  32'h0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(0,0,32'h0,        1,32'h100,0, 0,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(0,1,32'hDEADBEEF, 0,32'h0,  1, 1,32'h100, 0,32'h0,  32'h0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(0,1,32'h12345678, 1,32'h140,1, 1,32'h140, 0,32'h0,  32'h0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(0,1,32'h00000033, 0,32'h0,  0, 0,32'h0,   1,32'h140,32'h00000033));
    vecs.push_back(mk(0,0,32'h0,        1,32'h200,1, 1,32'h200, 0,32'h0,  32'h0));
    vecs.push_back(mk(1,0,32'h0,        0,32'h0,  0, 0,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(0,1,32'h000000B3, 0,32'h0,  0, 0,32'h0,   1,32'h200,32'h000000B3));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,  1, 1,32'h204, 0,32'h0,  32'h0));
    vecs.push_back(mk(0,0,32'h0,        1,32'h300,0, 1,32'h300, 0,32'h0,  32'h0));
    vecs.push_back(mk(0,0,32'h0,        0,32'h0,  0, 1,32'h300, 0,32'h0,  32'h0));
    vecs.push_back(mk(1,0,32'h0,        1,32'h400,0, 0,32'h0,   0,32'h0,  32'h0));
    vecs.push_back(mk(0,1,32'hCAFEF00D, 0,32'h0,  0, 1,32'h400, 0,32'h0,  32'h0));
    vecs.push_back(mk(0,1,32'h11111111, 0,32'h0,  1, 1,32'h400, 0,32'h0,  32'h0));

    // ---- reset state ----
    tick(); tick();
    chk("rst_req",    64'(imem_req),  64'(0));
    chk("rst_addr",   64'(imem_addr), 64'(32'h0));
    chk("rst_valid",  64'(if_valid),  64'(0));
    chk("rst_instr",  64'(if_instr),  64'(32'h13));
    chk("rst_pc",     64'(if_pc),     64'(32'h0));
    chk("rst_opcode", 64'(if_opcode), 64'(7'h13));
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", 64'(fetch_misalign), 64'(0));
`endif
    reset = 1'b1;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
      redirect_valid = vecs[i].rdir; redirect_pc = vecs[i].rdir_pc; if_ready = vecs[i].ready;
      tick();
      chk($sformatf("v%0d_req", i),   64'(imem_req), 64'(vecs[i].e_req));
      chk($sformatf("v%0d_valid", i), 64'(if_valid), 64'(vecs[i].e_valid));
      if (vecs[i].e_req)
        chk($sformatf("v%0d_addr", i), 64'(imem_addr), 64'(vecs[i].e_addr));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pc", i),     64'(if_pc),     64'(vecs[i].e_pc));
        chk($sformatf("v%0d_instr", i),  64'(if_instr),  64'(vecs[i].e_instr));
        chk($sformatf("v%0d_opcode", i), 64'(if_opcode), 64'(vecs[i].e_instr[6:0]));
      end
    end

    // ---- misaligned redirect from HOLD ----
    drive_idle(); imem_gnt = 1'b1; tick();
    drive_idle(); imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; tick();
    chk("mis_hold_valid", 64'(if_valid), 64'(1));
    chk("mis_hold_pc",    64'(if_pc),    64'(32'h400));
    drive_idle(); redirect_valid = 1'b1; redirect_pc = 32'h102; tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag",  64'(fetch_misalign), 64'(1));
    chk("mis_req",   64'(imem_req),       64'(0));
    chk("mis_valid", 64'(if_valid),       64'(0));
    for (int k = 0; k < 3; k++) begin
      imem_gnt = 1'b1; imem_rvalid = 1'b1; if_ready = 1'b1;
      redirect_valid = (k == 1); redirect_pc = 32'h500;
      tick();
      chk($sformatf("fault%0d_req", k),  64'(imem_req),       64'(0));
      chk($sformatf("fault%0d_flag", k), 64'(fetch_misalign), 64'(1));
      chk($sformatf("fault%0d_valid", k),64'(if_valid),       64'(0));
    end
`else
    chk("mis_req",   64'(imem_req),  64'(1));
    chk("mis_addr",  64'(imem_addr), 64'(32'h100));
    chk("mis_valid", 64'(if_valid),  64'(0));
`endif

    // ---- randomized run against the fetch-stream model ----
    drive_idle(); reset = 1'b0; tick(); tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst2_misalign", 64'(fetch_misalign), 64'(0));
`endif
    reset = 1'b1;
    exp_q.delete();
    exp_q.push_back({32'h0, mem_word(32'h0)});
    pend = 1'b0; wait_cnt = 0; n_deliv = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (imem_req) chk("rnd_addr", 64'(imem_addr), 64'(exp_q[0][63:32]));
      if (pend) begin
        if (wait_cnt == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr); pend = 1'b0;
        end else begin
          imem_rvalid = 1'b0; imem_rdata = $urandom; wait_cnt--;
        end
      end else begin
        imem_rvalid = ($urandom_range(0, 7) == 0);
        imem_rdata  = $urandom;
      end
      imem_gnt       = ($urandom_range(0, 9) < 7);
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = (cyc >= 3) && ($urandom_range(0, 11) == 0);
      tgt = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      redirect_pc = tgt;
      etgt = {tgt[31:2], 2'b00};
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back({etgt, mem_word(etgt)});
      end else if (if_valid && if_ready) begin
        chk("rnd_pc",     64'(if_pc),     64'(exp_q[0][63:32]));
        chk("rnd_instr",  64'(if_instr),  64'(exp_q[0][31:0]));
        chk("rnd_opcode", 64'(if_opcode), 64'(exp_q[0][6:0]));
        npc = exp_q[0][63:32] + 32'd4;
        void'(exp_q.pop_front());
        exp_q.push_back({npc, mem_word(npc)});
        n_deliv++;
      end
      granted  = imem_req && imem_gnt;
      req_addr = imem_addr;
      tick();
      if (granted) begin
        pend = 1'b1; pend_addr = req_addr; wait_cnt = $urandom_range(0, 2);
      end
    end
    chk("rnd_progress", 64'(n_deliv >= 30), 64'(1));
    drive_idle();

    // ---- RESET_PC at top of memory: wrap and reset mid-WAIT ----
    tick();
    chk("b_rst_req",   64'(b_req),   64'(0));
    chk("b_rst_addr",  64'(b_addr),  64'(32'hFFFF_FFFC));
    chk("b_rst_pc",    64'(b_pc),    64'(32'hFFFF_FFFC));
    chk("b_rst_instr", 64'(b_instr), 64'(32'h13));
    b_reset = 1'b1; tick();
    chk("b_req0",  64'(b_req),  64'(1));
    chk("b_addr0", 64'(b_addr), 64'(32'hFFFF_FFFC));
    b_gnt = 1'b1; tick();
    b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = 32'h0040_006F; tick();
    chk("b_valid0", 64'(b_valid), 64'(1));
    chk("b_pc0",    64'(b_pc),    64'(32'hFFFF_FFFC));
    chk("b_instr0", 64'(b_instr), 64'(32'h0040_006F));
    b_rvalid = 1'b0; b_ready = 1'b1; tick();
    chk("b_wrap_req",  64'(b_req),  64'(1));
    chk("b_wrap_addr", 64'(b_addr), 64'(32'h0));
    b_ready = 1'b0; b_gnt = 1'b1; tick();
    chk("b_wait_req", 64'(b_req), 64'(0));
    b_gnt = 1'b0; b_reset = 1'b0; tick();
    chk("b_mid_req",    64'(b_req),    64'(0));
    chk("b_mid_valid",  64'(b_valid),  64'(0));
    chk("b_mid_pc",     64'(b_pc),     64'(32'hFFFF_FFFC));
    chk("b_mid_opcode", 64'(b_opcode), 64'(7'h13));
    b_rvalid = 1'b1; b_rdata = 32'h0000_0BAD; tick();
    b_reset = 1'b1; tick();
    chk("b_after_req",   64'(b_req),   64'(1));
    chk("b_after_addr",  64'(b_addr),  64'(32'hFFFF_FFFC));
    chk("b_after_valid", 64'(b_valid), 64'(0));
    tick();
    chk("b_stray_req",   64'(b_req),   64'(1));
    chk("b_stray_valid", 64'(b_valid), 64'(0));
    b_rvalid = 1'b0; b_gnt = 1'b1; tick();
    b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = 32'h00A0_0093; tick();
    chk("b_refetch_valid", 64'(b_valid), 64'(1));
    chk("b_refetch_pc",    64'(b_pc),    64'(32'hFFFF_FFFC));
    chk("b_refetch_instr", 64'(b_instr), 64'(32'h00A0_0093));
    b_rvalid = 1'b0;

    // ---- report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
